// File: rtl/core_types_pkg.sv
// Shared types for the instruction-fetch slice: word type, queue entry layout
// and the fetch control state encoding.
package core_types_pkg;

  localparam int unsigned DEFAULT_FETCH_QUEUE_DEPTH = 4;
  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic [1:0] {
    StFetch     = 2'd0,
    StStallFull = 2'd1,
    StHalted    = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue with occupancy count; flush empties it and wins
// over a same-cycle enqueue or dequeue.
module fetch_queue
  import core_types_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FETCH_QUEUE_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               i_enq,
  input  logic [ENTRY_W-1:0] i_enq_data,
  input  logic               i_deq,
  input  logic               i_flush,
  output logic [ENTRY_W-1:0] o_head,
  output logic [CNT_W-1:0]   o_count
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_enq;
  logic               w_do_deq;

  assign w_do_enq = i_enq & (r_count != CNT_W'(DEPTH));
  assign w_do_deq = i_deq & (r_count != '0);

  // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_do_deq) r_head <= r_head + PTR_W'(1);
      unique case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_enq && !i_flush) begin
      r_mem[r_tail] <= i_enq_data;
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation against a blocking i$, redirect
// and sticky halt handling, and a decoupling queue towards decode.
module fetch_unit
  import core_types_pkg::*;
#(
  parameter int unsigned FETCH_QUEUE_DEPTH = DEFAULT_FETCH_QUEUE_DEPTH,
  parameter logic [31:0] RESET_PC          = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        DUT_error,
  output logic        icache_REN,
  output logic [31:0] icache_addr,
  output logic        icache_halt,
  input  logic        icache_hit,
  input  logic [31:0] icache_load,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int unsigned CNT_W = $clog2(FETCH_QUEUE_DEPTH) + 1;

  word_t              r_pc;
  logic               r_halted;
  logic               r_dut_error;
  fetch_state_t       r_state;
  fetch_state_t       w_state_d;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_full;
  logic               w_enq;
  logic               w_deq;
  fetch_entry_t       w_enq_entry;
  fetch_entry_t       w_head;
  logic [ENTRY_W-1:0] w_head_bits;

  // Issue decision uses registered occupancy only; a dequeue this cycle does
  // not free a slot until the next one.
  assign w_full      = (w_count == CNT_W'(FETCH_QUEUE_DEPTH));
  assign icache_REN  = ~r_halted & ~redirect_valid & ~w_full;
  assign icache_addr = r_pc;
  assign icache_halt = r_halted;

  assign w_enq = icache_REN & icache_hit;
  assign w_deq = fetch_valid & fetch_ready & ~redirect_valid;

  assign w_enq_entry = '{pc: r_pc, instr: icache_load};

  fetch_queue #(
    .DEPTH(FETCH_QUEUE_DEPTH)
  ) u_queue (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_enq     (w_enq),
    .i_enq_data(w_enq_entry),
    .i_deq     (w_deq),
    .i_flush   (redirect_valid),
    .o_head    (w_head_bits),
    .o_count   (w_count)
  );

  assign w_head      = fetch_entry_t'(w_head_bits);
  assign fetch_valid = (w_count != '0);
  assign fetch_instr = w_head.instr;
  assign fetch_pc    = w_head.pc;
  assign DUT_error   = r_dut_error;

  always_comb begin
    w_count_nxt = w_count;
    if (redirect_valid) begin
      w_count_nxt = '0;
    end else if (w_enq && !w_deq) begin
      w_count_nxt = w_count + CNT_W'(1);
    end else if (!w_enq && w_deq) begin
      w_count_nxt = w_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (r_state == StHalted) begin
      w_state_d = StHalted;
    end else if (redirect_valid) begin
      w_state_d = StFetch;
    end else if (halt) begin
      w_state_d = StHalted;
    end else if (w_count_nxt == CNT_W'(FETCH_QUEUE_DEPTH)) begin
      w_state_d = StStallFull;
    end else begin
      w_state_d = StFetch;
    end
  end

  // A same-cycle redirect takes precedence, so halt is only latched without one.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc        <= RESET_PC;
      r_halted    <= 1'b0;
      r_state     <= StFetch;
      r_dut_error <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_dut_error <= icache_hit & ~icache_REN;
      if (halt && !redirect_valid) r_halted <= 1'b1;
      if (redirect_valid) begin
        r_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_enq) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter FETCH_QUEUE_DEPTH, default 4, instruction queue entries (power of two).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 The block SHALL have the following ports:
- CLK  in  1  clock, all state on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- DUT_error  out  1  registered protocol-error flag.
- icache_REN  out  1  i$ read request.
- icache_addr  out  word_t  byte address of request (= PC).
- icache_halt  out  1  halt indication to i$.
- icache_hit  in  1  i$ response valid, same cycle as request.
- icache_load  in  word_t  instruction word.
- fetch_valid  out  1  queue head valid to decode.
- fetch_ready  in  1  decode accepts head.
- fetch_instr  out  word_t  head instruction.
- fetch_pc  out  word_t  head PC.
- redirect_valid  in  1  backend flush/redirect.
- redirect_pc  in  word_t  new PC.
- halt  in  1  backend halt request.

Function
REQ-004 The block SHALL hold PC register pc; icache_addr SHALL equal pc combinationally.
REQ-005 icache_REN SHALL be 1 iff not halted, redirect_valid=0, and queue count < FETCH_QUEUE_DEPTH, evaluated on registered count only (no same-cycle dequeue credit).
REQ-006 On icache_REN & icache_hit, {pc, icache_load} SHALL be enqueued at tail and pc SHALL become pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-007 On icache_REN & ~icache_hit, pc and queue tail SHALL hold; request repeats next cycle (blocking i$ protocol).
REQ-008 fetch_valid SHALL be 1 iff count>0; fetch_instr/fetch_pc SHALL show head entry; dequeue occurs on fetch_valid & fetch_ready.
REQ-009 Simultaneous enqueue and dequeue SHALL leave count unchanged; head/tail pointers wrap modulo FETCH_QUEUE_DEPTH.
REQ-010 redirect_valid=1 SHALL, next edge: empty queue (count=0, pointers 0), pc <= redirect_pc, discard same-cycle hit and dequeue; redirect wins over all other events including halt.
REQ-011 halt=1 SHALL set sticky register halted; once halted, icache_REN=0, icache_halt=1, queue continues draining to decode; only reset clears halted.
REQ-012 redirect_pc with bits[1:0]!=0 SHALL be accepted with bits[1:0] forced to 0.
REQ-013 next_DUT_error SHALL be 1 when icache_hit=1 while icache_REN=0; DUT_error registers it, one cycle latency.
REQ-014 State machine: FETCH (normal), STALL_FULL (count=FETCH_QUEUE_DEPTH), HALTED (terminal); FETCH<->STALL_FULL by count, any -> HALTED on halt, redirect returns FETCH/STALL_FULL to FETCH.

Reset
REQ-015 On nRST=0: pc=RESET_PC, count=0, pointers=0, halted=0, state=FETCH, DUT_error=0; outputs therefore fetch_valid=0, icache_halt=0, icache_REN=1 after reset release.
REQ-016 Reset mid-operation SHALL discard queue contents and pending requests immediately (asynchronous).

Structure
REQ-017 core_types_pkg SHALL hold FETCH_QUEUE_DEPTH default, fetch_entry_t {pc, instr} and fetch_state_t.
REQ-018 Queue SHALL be sub-module fetch_queue (circular buffer, count, enq/deq/flush); fetch_unit holds PC, halt and control.

Verification
REQ-019 Reset, i$ hits every cycle, fetch_ready=1 -> fetch_pc 0,4,8,12 on consecutive cycles, one cycle after each hit.
REQ-020 fetch_ready=0, hits every cycle -> 4 enqueues (pc 0..12), then icache_REN=0 with pc=16; fetch_ready=1 one cycle -> REN=1 next cycle.
REQ-021 icache_hit=0 for 3 cycles at pc=8 -> icache_addr stays 8, no enqueue; hit in 4th cycle -> entry pc=8 enqueued, pc=12.
REQ-022 Queue holding 3 entries, redirect_valid=1 with redirect_pc=32'h0000_0103 and hit same cycle -> next cycle fetch_valid=0, icache_addr=32'h0000_0100.
REQ-023 halt=1 with 2 entries queued -> icache_halt=1, REN=0 permanently, both entries still delivered in order; icache_hit pulsed while REN=0 -> DUT_error=1 next cycle.
